alu_share_arbiter: RTL

Two-port arbiter and sequencer that shares a single 16-bit logic ALU (module `alu`, instantiated internally) between two requesters. Each requester presents operands and a 3-bit function code under a req/ack handshake. The block grants one requester at a time, latches its operands, drives the shared ALU, and returns a registered result with a per-port completion pulse. It sits between the datapath clients and the ALU so that neither client needs its own instance.

---
 rtl/alu_share_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one 16-bit logic ALU between two req/ack requesters.
// Each operation takes two cycles: grant/latch in IDLE, then compute in EXEC.

module alu #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_func,
  output logic [DATA_W-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_func)
      3'b001:  o_y = ~i_b;
      3'b010:  o_y = i_a & i_b;
      3'b011:  o_y = i_a | i_b;
      3'b100:  o_y = i_a ^ i_b;
      3'b101:  o_y = ~(i_a ^ i_b);
      3'b110:  o_y = ~(i_a | i_b);
      3'b111:  o_y = ~(i_a & i_b);
      default: o_y = '0;
    endcase
  end

endmodule

module alu_share_arbiter #(
  parameter int unsigned FAIR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  input  logic [2:0]  func0,
  input  logic [2:0]  func1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] result,
  output logic        busy,
  output logic [7:0]  ops
);

  localparam int DATA_W = 16;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_take;
  logic                w_grant;
  logic                r_win;
  logic                r_last;
  logic                r_ack0;
  logic                r_ack1;
  logic                r_done0;
  logic                r_done1;
  logic [7:0]          r_ops;
  logic [DATA_W-1:0]   r_a_p0;
  logic [DATA_W-1:0]   r_b_p0;
  logic [2:0]          r_func_p0;
  logic [DATA_W-1:0]   r_result_p1;
  logic [DATA_W-1:0]   w_alu_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Winner selection: a lone requester always wins; contention uses the
  // last-grant pointer when fair, otherwise port 0.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_take      = 1'b1;
          w_state_nxt = S_EXEC;
          if (req0 && req1) begin
            w_grant = (FAIR != 0) ? ~r_last : 1'b0;
          end else begin
            w_grant = req1;
          end
        end
      end
      S_EXEC: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Stage p0: grant, latch operands and pulse ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_win     <= 1'b0;
      r_a_p0    <= '0;
      r_b_p0    <= '0;
      r_func_p0 <= '0;
    end else begin
      r_ack0 <= w_take & ~w_grant;
      r_ack1 <= w_take & w_grant;
      if (w_take) begin
        r_win     <= w_grant;
        r_a_p0    <= w_grant ? a1 : a0;
        r_b_p0    <= w_grant ? b1 : b0;
        r_func_p0 <= w_grant ? func1 : func0;
      end
    end
  end

  alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_a    (r_a_p0),
    .i_b    (r_b_p0),
    .i_func (r_func_p0),
    .o_y    (w_alu_y)
  );

  // Stage p1: capture the ALU output on leaving EXEC and signal completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_result_p1 <= '0;
      r_ops       <= 8'h00;
      r_last      <= 1'b1;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (r_state == S_EXEC) begin
        r_result_p1 <= w_alu_y;
        r_done0     <= ~r_win;
        r_done1     <= r_win;
        r_ops       <= r_ops + 8'd1;
        r_last      <= r_win;
      end
    end
  end

  assign ack0   = r_ack0;
  assign ack1   = r_ack1;
  assign done0  = r_done0;
  assign done1  = r_done1;
  assign result = r_result_p1;
  assign busy   = (r_state == S_EXEC);
  assign ops    = r_ops;

endmodule
